// File: rtl/decode_queue_ctrl_pkg.sv
// Shared opcode constants, instruction field positions and record types for the decode queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decode_queue_ctrl_pkg;

    // Opcodes the decoder distinguishes
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Instruction field bit ranges
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int F7_MSB  = 31;
    localparam int F7_LSB  = 25;

    // One queue slot: raw fetched word plus its PC
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } q_entry_t;

    // Registered contents of the decode stage
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        use_imm;
        logic        has_rd;
    } dec_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_queue_ctrl_imm.sv
// Immediate extractor: 12-bit immediate by opcode, sign-extended, plus use_imm / has_rd flags.
// Latency: purely combinational.
// Backpressure: none.
// Ports: instr (in, 32) -> imm (32), use_imm, has_rd.
module decode_imm_ext
    import decode_queue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        has_rd
);

    logic [6:0]  op;
    logic [11:0] imm12;

    assign op = instr[OPC_MSB:OPC_LSB];

    always_comb begin
        imm12   = '0;
        use_imm = 1'b0;
        case (op)
            OP_IMM, OP_LOAD: begin
                imm12   = instr[31:20];
                use_imm = 1'b1;
            end
            OP_STORE: begin
                imm12   = {instr[31:25], instr[11:7]};
                use_imm = 1'b1;
            end
            OP_BRANCH: begin
                // Halfword offset: the implicit zero LSB is left to downstream.
                imm12   = {instr[31], instr[7], instr[30:25], instr[11:8]};
                use_imm = 1'b1;
            end
            default: begin
                imm12   = '0;
                use_imm = 1'b0;
            end
        endcase
    end

    assign imm    = sext12(imm12);
    assign has_rd = (op != OP_STORE) && (op != OP_BRANCH);

    // rs1/funct3 bits never feed an immediate
    logic unused_fields;
    assign unused_fields = ^instr[19:12];

endmodule

// File: rtl/decode_queue_ctrl.sv
// Decode sequencer: circular fetch queue feeding a registered decode stage toward rename.
// Latency: push at edge E -> out_valid at E+1 earliest; 1 instr/cycle sustained.
// Backpressure: in_ready = queue not full (state only); !out_ready freezes the decode stage.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_instr/in_pc from fetch;
//        out_valid/out_ready plus registered decoded fields to rename; count = queue occupancy.
module decode_queue_ctrl
    import decode_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_use_imm,
    output logic             out_has_rd,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;
    dec_t             dec_q;
    logic             vld_q;

    logic             push;
    logic             load_en;
    q_entry_t         head_ent;
    logic [31:0]      head_imm;
    logic             head_use_imm;
    logic             head_has_rd;

    // Full/empty come from the occupancy counter, never from pointer compare.
    assign in_ready = (cnt != FULL);
    assign push     = in_valid && in_ready;
    assign load_en  = (cnt != '0) && (!vld_q || out_ready);
    assign head_ent = mem[head];

    decode_imm_ext u_imm (
        .instr   (head_ent.instr),
        .imm     (head_imm),
        .use_imm (head_use_imm),
        .has_rd  (head_has_rd)
    );

    // Storage needs no reset; occupancy decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[tail] <= '{instr: in_instr, pc: in_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (load_en) begin
                head <= head + 1'b1;
            end
            case ({push, load_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dec_q <= '0;
            vld_q <= 1'b0;
        end else if (load_en) begin
            dec_q.instr   <= head_ent.instr;
            dec_q.pc      <= head_ent.pc;
            dec_q.opcode  <= head_ent.instr[OPC_MSB:OPC_LSB];
            dec_q.rd      <= head_has_rd ? head_ent.instr[RD_MSB:RD_LSB] : 5'd0;
            dec_q.rs1     <= head_ent.instr[RS1_MSB:RS1_LSB];
            dec_q.rs2     <= head_ent.instr[RS2_MSB:RS2_LSB];
            dec_q.funct3  <= head_ent.instr[F3_MSB:F3_LSB];
            dec_q.funct7  <= head_ent.instr[F7_MSB:F7_LSB];
            dec_q.imm     <= head_imm;
            dec_q.use_imm <= head_use_imm;
            dec_q.has_rd  <= head_has_rd;
            vld_q         <= 1'b1;
        end else if (vld_q && out_ready) begin
            // Consumed with nothing queued behind it
            vld_q <= 1'b0;
        end
    end

    assign out_valid   = vld_q;
    assign out_instr   = dec_q.instr;
    assign out_pc      = dec_q.pc;
    assign out_opcode  = dec_q.opcode;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_funct3  = dec_q.funct3;
    assign out_funct7  = dec_q.funct7;
    assign out_imm     = dec_q.imm;
    assign out_use_imm = dec_q.use_imm;
    assign out_has_rd  = dec_q.has_rd;
    assign count       = cnt;

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Bench for decode_queue_ctrl: decode vector table, backpressure/wrap, flush, streaming.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_decode_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_use_imm, out_has_rd;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_queue_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_has_rd(out_has_rd), .count(count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        use_imm;
        logic        has_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits (on negedges) until out_valid, at most 'bound' cycles.
    task automatic wait_out(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit          ok;
        int          idx, got, gaps, maxcnt, seen;
        bit          rdy_now, hs_now;
        logic [31:0] exp_pc;

        vecs[0] = '{32'hFFF00093, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[1] = '{32'h0020A423, 5'd0, 5'd1, 5'd2,  3'd2, 7'h00, 32'h00000008, 1'b1, 1'b0};
        vecs[2] = '{32'h80000063, 5'd0, 5'd0, 5'd0,  3'd0, 7'h40, 32'hFFFFF800, 1'b1, 1'b0};
        vecs[3] = '{32'h002081B3, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{32'h00412183, 5'd3, 5'd2, 5'd4,  3'd2, 7'h00, 32'h00000004, 1'b1, 1'b1};
        vecs[5] = '{32'hFE20AE23, 5'd0, 5'd1, 5'd2,  3'd2, 7'h7F, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[6] = '{32'h00209463, 5'd0, 5'd1, 5'd2,  3'd1, 7'h00, 32'h00000004, 1'b1, 1'b0};
        vecs[7] = '{32'h123450B7, 5'd1, 5'd8, 5'd3,  3'd5, 7'h09, 32'h00000000, 1'b0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset count",     32'(count),     32'd0);
        chk("reset out_instr", out_instr,      32'd0);
        chk("reset out_pc",    out_pc,         32'd0);

        // Decode table: one push per vector, rename always ready.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d not yet valid", i), 32'(out_valid), 32'd0);
            wait_out(4, ok);
            chk($sformatf("vec%0d out_valid", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d pc", i),     out_pc,            32'h1000 + 32'(i * 4));
            chk($sformatf("vec%0d instr", i),  out_instr,         vecs[i].instr);
            chk($sformatf("vec%0d opcode", i), 32'(out_opcode),   32'(vecs[i].instr & 32'h7F));
            chk($sformatf("vec%0d rd", i),     32'(out_rd),       32'(vecs[i].rd));
            chk($sformatf("vec%0d rs1", i),    32'(out_rs1),      32'(vecs[i].rs1));
            chk($sformatf("vec%0d rs2", i),    32'(out_rs2),      32'(vecs[i].rs2));
            chk($sformatf("vec%0d funct3", i), 32'(out_funct3),   32'(vecs[i].f3));
            chk($sformatf("vec%0d funct7", i), 32'(out_funct7),   32'(vecs[i].f7));
            chk($sformatf("vec%0d imm", i),    out_imm,           vecs[i].imm);
            chk($sformatf("vec%0d use_imm", i), 32'(out_use_imm), 32'(vecs[i].use_imm));
            chk($sformatf("vec%0d has_rd", i), 32'(out_has_rd),   32'(vecs[i].has_rd));
            @(negedge clk);
            chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: 6 offered with rename stalled; decode stage + 4 queue slots take 5.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            in_instr = 32'h00000013 | 32'(idx << 7);
            in_pc    = 32'h200 + 32'(idx * 4);
            rdy_now  = in_ready;
            @(negedge clk);
            if (in_valid && rdy_now) idx++;
        end
        chk("stall accepted", 32'(idx), 32'd5);
        chk("stall count", 32'(count), 32'd4);
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall out_valid", 32'(out_valid), 32'd1);
        chk("stall out_pc held", out_pc, 32'h200);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            in_valid = (idx < 6);
            in_instr = 32'h00000013 | 32'(idx << 7);
            in_pc    = 32'h200 + 32'(idx * 4);
            rdy_now  = in_ready;
            if (out_valid) begin
                chk($sformatf("wrap pc%0d", got), out_pc, 32'h200 + 32'(got * 4));
                chk($sformatf("wrap rd%0d", got), 32'(out_rd), 32'(got));
                got++;
            end
            @(negedge clk);
            if (in_valid && rdy_now) idx++;
        end
        in_valid = 1'b0;
        chk("wrap delivered", 32'(got), 32'd6);

        // Flush with a simultaneous push.
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10 && idx < 4; c++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000013;
            in_pc    = 32'h300 + 32'(idx * 4);
            rdy_now  = in_ready;
            @(negedge clk);
            if (rdy_now) idx++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("preflush count", 32'(count), 32'd3);
        chk("preflush out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'hDEAD0000;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush out_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flushed push absent", 32'(seen), 32'd0);
        in_valid = 1'b1; in_instr = 32'h00700113; in_pc = 32'h400;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(4, ok);
        chk("postflush valid", 32'(ok), 32'd1);
        chk("postflush pc", out_pc, 32'h400);
        @(negedge clk);

        // Streaming: one push per cycle for 20 cycles, rename always ready.
        got = 0; gaps = 0; maxcnt = 0; exp_pc = 32'h0;
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 20);
            in_instr = 32'h00000033;
            in_pc    = 32'(c * 4);
            hs_now   = out_valid;
            if (out_valid) begin
                if (out_pc !== exp_pc) begin
                    gaps++;
                    $display("FAIL stream pc: got 0x%08h expected 0x%08h", out_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end else if (c >= 2 && got < 20) begin
                gaps++;
            end
            if (32'(count) > maxcnt) maxcnt = 32'(count);
            @(negedge clk);
            if (hs_now) begin end
        end
        in_valid = 1'b0;
        chk("stream delivered", 32'(got), 32'd20);
        chk("stream gaps/order", 32'(gaps), 32'd0);
        chk("stream max count<=1", 32'(maxcnt <= 1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
